// File: rtl/encoder_ctrl_pkg.sv
// rtl/encoder_ctrl_pkg.sv - shared types and constants for the encoder scheduler
package encoder_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COLLECT = 3'd1,
        BURST   = 3'd2,
        RUN     = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam logic [1:0] LOAD_MODE = 2'b00;
    localparam int BURST_LEN = 8;
    localparam int BUF_PTR_W = $clog2(BURST_LEN);

    typedef logic [BUF_PTR_W:0] buf_cnt_t;

    // Two-requester round robin: the favoured side only matters on a tie.
    function automatic logic [1:0] rr_pick(input logic [1:0] r, input logic favour_b);
        if (r == 2'b11) begin
            return favour_b ? 2'b10 : 2'b01;
        end
        return r;
    endfunction

endpackage

// File: rtl/enc_burst_buf.sv
// rtl/enc_burst_buf.sv - 8x8 byte store filled during collect, drained during burst
module enc_burst_buf
    import encoder_ctrl_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           wr_en,
    input  logic [7:0]     wr_data,
    input  logic           rd_en,
    output logic [7:0]     rd_data,
    output buf_cnt_t       count
);

    logic [7:0]           mem [BURST_LEN];
    logic [BUF_PTR_W-1:0] wr_ptr;
    logic [BUF_PTR_W-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            count <= count + buf_cnt_t'(wr_en) - buf_cnt_t'(rd_en);
        end
    end

    // Contents need no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/encoder_scheduler.sv
// rtl/encoder_scheduler.sv - two-requester arbiter that collects, bursts and runs a shared encoder
module encoder_scheduler
    import encoder_ctrl_pkg::*;
#(
    parameter int OUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req,
    input  logic [1:0]  req_valid,
    input  logic [15:0] req_data,
    input  logic [3:0]  req_mode,
    input  logic [7:0]  req_max,
    input  logic [7:0]  req_min,
    output logic [1:0]  req_ready,
    output logic [1:0]  grant,
    output logic [1:0]  done,
    output logic        enc_in_valid,
    output logic [7:0]  enc_in_data,
    output logic [1:0]  enc_mode,
    output logic [3:0]  enc_max,
    output logic [3:0]  enc_min,
    output logic        busy,
    output logic [2:0]  state
);

    state_t     state_q, state_n;
    logic       ptr;
    logic [1:0] pick, own_n;
    logic [1:0] mode_q;
    logic [7:0] run_cnt;
    logic       accept, rd_en;
    logic [7:0] wr_data, rd_data;
    buf_cnt_t   buf_count;
    logic [1:0] cfg_mode;
    logic [3:0] cfg_max, cfg_min;

    enc_burst_buf u_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (accept),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_data (rd_data),
        .count   (buf_count)
    );

    always_comb begin
        pick     = rr_pick(req, ptr);
        own_n    = (state_q == IDLE) ? pick : grant;
        accept   = (state_q == COLLECT) && |(req_ready & req_valid);
        wr_data  = grant[1] ? req_data[15:8] : req_data[7:0];
        cfg_mode = pick[1] ? req_mode[3:2] : req_mode[1:0];
        cfg_max  = pick[1] ? req_max[7:4]  : req_max[3:0];
        cfg_min  = pick[1] ? req_min[7:4]  : req_min[3:0];
        state_n  = state_q;
        case (state_q)
            IDLE:    if (|req) state_n = COLLECT;
            COLLECT: if (accept && buf_count == buf_cnt_t'(BURST_LEN - 1)) state_n = BURST;
            BURST:   if (buf_count == '0) state_n = RUN;
            RUN:     if (run_cnt == 8'(OUT_CYCLES - 1)) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
        // Each burst cycle pops the byte the next cycle will present.
        rd_en = (state_n == BURST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            ptr          <= 1'b0;
            mode_q       <= LOAD_MODE;
            run_cnt      <= '0;
            grant        <= '0;
            done         <= '0;
            req_ready    <= '0;
            enc_in_valid <= 1'b0;
            enc_in_data  <= '0;
            enc_mode     <= LOAD_MODE;
            enc_max      <= '0;
            enc_min      <= '0;
            busy         <= 1'b0;
        end else begin
            state_q      <= state_n;
            busy         <= (state_n != IDLE);
            done         <= (state_n == DONE) ? grant : 2'b00;
            req_ready    <= (state_n == COLLECT) ? own_n : 2'b00;
            enc_in_valid <= (state_n == BURST);
            enc_in_data  <= (state_n == BURST) ? rd_data : 8'h00;
            enc_mode     <= (state_n == RUN) ? mode_q : LOAD_MODE;
            run_cnt      <= (state_q == RUN) ? run_cnt + 8'd1 : 8'd0;
            if (state_q == IDLE && |req) begin
                grant   <= pick;
                mode_q  <= cfg_mode;
                enc_max <= (cfg_min > cfg_max) ? cfg_min : cfg_max;
                enc_min <= (cfg_min > cfg_max) ? cfg_max : cfg_min;
            end else if (state_q == DONE) begin
                grant <= 2'b00;
                ptr   <= grant[0];
            end
        end
    end

    assign state = state_q;

endmodule

// File: doc/encoder_scheduler.md
ENCODER_SCHEDULER -- requirements
Module: encoder_scheduler

Interface
REQ-001 Parameter SHALL be: OUT_CYCLES, 16, encoder output-phase length in cycles (range 1..255).
REQ-002 clk  input  1  single clock, all logic on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 req  input  2  per-requester transaction request, bit0 = A, bit1 = B.
REQ-005 req_valid  input  2  per-requester data byte valid.
REQ-006 req_data  input  16  per-requester data byte, [7:0] = A, [15:8] = B.
REQ-007 req_mode  input  4  per-requester encoder mode, [1:0] = A, [3:2] = B.
REQ-008 req_max  input  8  per-requester counter max, [3:0] = A, [7:4] = B.
REQ-009 req_min  input  8  per-requester counter min, [3:0] = A, [7:4] = B.
REQ-010 req_ready  output  2  byte accepted when req_valid & req_ready.
REQ-011 grant  output  2  one-hot owner of the encoder, or 0.
REQ-012 done  output  2  one-cycle completion pulse to the owner.
REQ-013 enc_in_valid  output  1  encoder in_valid.
REQ-014 enc_in_data  output  8  encoder in_data.
REQ-015 enc_mode  output  2  encoder mode.
REQ-016 enc_max / enc_min  output  4 each  encoder counter bounds.
REQ-017 busy  output  1  high whenever state != IDLE.
REQ-018 state  output  3  current state encoding, for debug.

Function
REQ-019 All outputs SHALL be registered.
REQ-020 States SHALL be IDLE=0, COLLECT=1, BURST=2, RUN=3, DONE=4; no other codes reachable.
REQ-021 IDLE: when req != 0 at edge n, grant SHALL go one-hot after edge n and state SHALL be COLLECT.
- Arbitration SHALL be round-robin: pointer-favoured requester wins on tie.
- Pointer SHALL reset to A.
REQ-022 On grant, the owner's mode/max/min SHALL be latched; later changes to the req_* config inputs SHALL be ignored until the next grant.
REQ-023 If latched min > max, the two values SHALL be swapped before driving enc_max/enc_min.
REQ-024 COLLECT behaviour:
- req_ready[owner] SHALL be 1 until 8 bytes are accepted; req_ready of the non-owner SHALL be 0.
- Stalls (req_valid = 0) SHALL be tolerated indefinitely.
REQ-025 After the 8th accepted byte, state SHALL become BURST.
- enc_in_valid SHALL be 1 for exactly 8 consecutive cycles.
- enc_in_data SHALL present the bytes in acceptance order.
- enc_mode SHALL be 2'b00 during BURST.
REQ-026 RUN: enc_in_valid = 0, enc_in_data = 0, enc_mode = latched mode, for exactly OUT_CYCLES cycles; then DONE.
REQ-027 DONE (one cycle) SHALL:
- assert done[owner];
- clear grant and set the pointer to the other requester;
- set enc_mode to 2'b00;
- return to IDLE.
REQ-028 Outside BURST/RUN: enc_in_valid = 0, enc_in_data = 0, enc_mode = 2'b00; enc_max/enc_min hold their last value.
REQ-029 Deassertion of req[owner] mid-transaction SHALL NOT abort the transaction; non-owner requests SHALL wait.
REQ-030 Back-to-back: a req held through DONE SHALL be granted in the cycle after IDLE is entered.

Reset
REQ-031 On rst at a clock edge:
- state = IDLE; grant, done, req_ready, enc_in_valid, enc_in_data, enc_mode = 0; busy = 0.
- enc_max = 4'd0; enc_min = 4'd0; pointer = A; byte count = 0; buffer contents are don't-care.
REQ-032 rst asserted mid-operation SHALL abort the transaction with no done pulse.

Structure
REQ-033 Shared package encoder_ctrl_pkg SHALL hold: the state enum, LOAD_MODE = 2'b00, BURST_LEN = 8.
REQ-034 The 8x8 byte store SHALL be sub-module enc_burst_buf (write pointer, read pointer, count).

Verification
REQ-035 A only, bytes 0x02..0x10 step 2, mode 2'b10, max 4, min 0, OUT_CYCLES = 16:
- grant = 01 one cycle after req;
- enc_in_valid high 8 cycles carrying 0x02..0x10;
- enc_mode = 10 for 16 cycles;
- done[0] one pulse.
REQ-036 A and B request in the same cycle after reset: A is served first; then B is served with B's bytes 0xE6..0xED; grant never 11.
REQ-037 Owner req_valid toggles 1-0-1 while collecting: BURST still emits the 8 bytes contiguously and in order.
REQ-038 B supplies min = 15, max = 2: enc_min = 2 and enc_max = 15 throughout the transaction.
REQ-039 rst asserted during the 4th RUN cycle: next cycle state = 0, grant = 0, no done pulse; a new req is granted normally.
